// File: rtl/fibo_bcd.sv
// ============================================================================
// fibo_bcd : sequential double-dabble binary-to-BCD converter, one bit/clock
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fibo_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CW     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WIDTH-1:0]      bin_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [3:0]            ndigits_o,
  output logic                  out_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      bin_sr_q, bin_sr_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [3:0]            ndig_q, ndig_d;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_shifted;
  logic [3:0]            w_ndig;
  logic                  w_last;

  // Add-3 correction per digit, then shift the next binary bit into the units digit.
  always_comb begin
    w_adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
      end
    end
    w_shifted = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_sr_q[WIDTH-1]};
  end

  always_comb begin
    w_ndig = 4'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shifted[4*d +: 4] != 4'd0) begin
        w_ndig = 4'(d + 1);
      end
    end
  end

  assign w_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ndig_d   = ndig_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          bin_sr_d = bin_i;
          work_d   = '0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d   = w_shifted;
        bin_sr_d = bin_sr_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (w_last) begin
          bcd_d   = w_shifted;
          ndig_d  = w_ndig;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      bin_sr_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ndig_q   <= 4'd1;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ndig_q   <= ndig_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign bcd_o       = bcd_q;
  assign ndigits_o   = ndig_q;

endmodule

`default_nettype wire

// File: tb/tb_fibo_bcd.sv
// ============================================================================
// tb_fibo_bcd : randomized self-checking bench for fibo_bcd against a decimal model
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_fibo_bcd;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic                clk;
  logic                rst_n;
  logic [WIDTH-1:0]    bin;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          ndigits;
  logic                out_valid;

  int total = 0;
  int bad   = 0;

  fibo_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(6)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bin_i      (bin),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .bcd_o      (bcd),
    .ndigits_o  (ndigits),
    .out_valid_o(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    longint x = longint'(v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_nd(input logic [WIDTH-1:0] v);
    longint x = longint'(v);
    int n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return 4'(n);
  endfunction

  function automatic bit work_digits_ok();
    logic [4*DIGITS-1:0] w = dut.work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL idle_wait: in_ready=%0b required=1", in_ready);
    end
  endtask

  // Accept v, then check latency, result, digit count and the post-DONE return to idle.
  task automatic convert(input logic [WIDTH-1:0] v, output logic [3:0] nd_seen);
    int  lat = 0;
    bit  nib_ok = 1'b1;
    wait_idle();
    bin = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (!work_digits_ok()) nib_ok = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    nd_seen = ndigits;
    total++;
    if (lat !== WIDTH) begin
      bad++;
      $display("FAIL latency v=%0d: got=%0d required=%0d", v, lat, WIDTH);
    end
    total++;
    if (bcd !== ref_bcd(v)) begin
      bad++;
      $display("FAIL bcd v=%0d: got=%h required=%h", v, bcd, ref_bcd(v));
    end
    total++;
    if (ndigits !== ref_nd(v)) begin
      bad++;
      $display("FAIL ndigits v=%0d: got=%0d required=%0d", v, ndigits, ref_nd(v));
    end
    total++;
    if (!nib_ok) begin
      bad++;
      $display("FAIL work_nibbles v=%0d: a digit exceeded 9 required<=9", v);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_done v=%0d: out_valid=%0b in_ready=%0b required 0/1", v, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bcd !== '0 || ndigits !== 4'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: bcd=%h nd=%0d rdy=%0b ov=%0b required 0/1/1/0", bcd, ndigits, in_ready, out_valid);
    end
  endtask

  task automatic test_zero();
    logic [3:0] nd;
    convert(32'd0, nd);
  endtask

  task automatic test_back_to_back();
    int first_ov = 0, rdy_at = 0, second_ov = 0;
    logic [4*DIGITS-1:0] bcd1 = '0;
    logic [3:0] nd1 = '0;
    wait_idle();
    bin = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    bin = 32'd832040;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (out_valid && first_ov == 0) begin
        first_ov = n;
        bcd1 = bcd;
        nd1 = ndigits;
      end else if (out_valid && second_ov == 0) begin
        second_ov = n;
        break;
      end
      if (in_ready && rdy_at == 0) rdy_at = n;
    end
    in_valid = 1'b0;
    total++;
    if (bcd1 !== 40'h0000000001 || nd1 !== 4'd1 || first_ov !== WIDTH) begin
      bad++;
      $display("FAIL b2b_first: bcd=%h nd=%0d at=%0d required 0000000001/1/%0d", bcd1, nd1, first_ov, WIDTH);
    end
    total++;
    if (rdy_at + 1 !== WIDTH + 2) begin
      bad++;
      $display("FAIL b2b_accept_edge: got=%0d required=%0d", rdy_at + 1, WIDTH + 2);
    end
    total++;
    if (second_ov !== 2*WIDTH + 2 || bcd !== 40'h0000832040 || ndigits !== 4'd6) begin
      bad++;
      $display("FAIL b2b_second: at=%0d bcd=%h nd=%0d required %0d/0000832040/6", second_ov, bcd, ndigits, 2*WIDTH + 2);
    end
  endtask

  task automatic test_wide();
    logic [3:0] nd;
    convert(32'd2971215073, nd);
    convert(32'hFFFFFFFF, nd);
  endtask

  task automatic test_busy_ignore();
    logic [WIDTH-1:0] v = $urandom;
    bit rdy_bad = 1'b0;
    int ov_at = 0;
    wait_idle();
    bin = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        bin = ~v;
        in_valid = 1'b1;
      end
      if (n == 7) in_valid = 1'b0;
      if (n <= WIDTH && in_ready) rdy_bad = 1'b1;
      if (out_valid) ov_at = n;
    end
    total++;
    if (rdy_bad || !in_ready) begin
      bad++;
      $display("FAIL busy_ready: early_ready=%0b final_ready=%0b required 0/1", rdy_bad, in_ready);
    end
    total++;
    if (ov_at !== WIDTH || bcd !== ref_bcd(v)) begin
      bad++;
      $display("FAIL busy_result: at=%0d bcd=%h required %0d/%h", ov_at, bcd, WIDTH, ref_bcd(v));
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] nd;
    bit ov_seen = 1'b0;
    convert(32'd55, nd);
    wait_idle();
    bin = $urandom | 32'h8000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bcd !== '0 || ndigits !== 4'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: bcd=%h nd=%0d rdy=%0b ov=%0b required 0/1/1/0", bcd, ndigits, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    total++;
    if (ov_seen) begin
      bad++;
      $display("FAIL abort_no_pulse: out_valid=1 required=0");
    end
    convert($urandom, nd);
  endtask

  task automatic test_random();
    logic [3:0] nd;
    for (int i = 0; i < 12; i++) begin
      convert($urandom >> $urandom_range(0, 31), nd);
    end
  endtask

  task automatic test_fibo();
    logic [WIDTH-1:0] a = 0, b = 1, t;
    logic [3:0] nd, prev_nd = 4'd1;
    bit wrapped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      convert(a, nd);
      if (!wrapped) begin
        total++;
        if (nd < prev_nd) begin
          bad++;
          $display("FAIL fibo_monotonic i=%0d: nd=%0d required>=%0d", i, nd, prev_nd);
        end
      end
      prev_nd = nd;
      t = a + b;
      a = b;
      b = t;
      if (b < a) wrapped = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bin = '0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_zero();
    test_back_to_back();
    test_wide();
    test_busy_ignore();
    test_async_reset();
    test_random();
    test_fibo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
